// File: rtl/rf_wr_arbiter_if.sv
// Write-port bundle between the two register-file write requesters and rf_wr_arbiter.
// The requester side uses the master modport; the arbiter uses the slave modport.
interface rf_wr_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_lock;
  logic        b_ready;
  logic        wr_en;
  logic [4:0]  wr_addr3;
  logic [31:0] wr_data3;
  logic        locked;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, b_lock,
    input  a_ready, b_ready, wr_en, wr_addr3, wr_data3, locked
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, b_lock,
    output a_ready, b_ready, wr_en, wr_addr3, wr_data3, locked
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Shares the register file's single write port between core writeback (A) and debug/loader (B).
// Define RF_WR_ARB_FIXED_PRIO_EN for A-always-wins tie-break instead of round-robin.
module rf_wr_arbiter (
  input logic         clk,
  input logic         rst_n,
  rf_wr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCK_B = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        last_b_r;
  logic        last_b_nxt_s;
  logic        a_grant_s;
  logic        b_grant_s;
  logic        a_ready_s;
  logic        b_ready_s;
  logic        a_xfer_s;
  logic        b_xfer_s;
  logic        wr_en_r;
  logic [4:0]  wr_addr_r;
  logic [31:0] wr_data_r;
  logic        locked_r;

  // Grant selection, handshake and next-state logic; ready never looks at addr/data.
  always_comb begin
    a_grant_s    = 1'b0;
    b_grant_s    = 1'b0;
    state_nxt_s  = state_r;
    last_b_nxt_s = last_b_r;

    case (state_r)
      ST_ARB: begin
        if (bus.a_valid && bus.b_valid) begin
`ifdef RF_WR_ARB_FIXED_PRIO_EN
          a_grant_s = 1'b1;
          b_grant_s = 1'b0;
`else
          a_grant_s = last_b_r;
          b_grant_s = ~last_b_r;
`endif
        end else if (bus.a_valid) begin
          a_grant_s = 1'b1;
        end else if (bus.b_valid) begin
          b_grant_s = 1'b1;
        end else begin
          a_grant_s = 1'b0;
          b_grant_s = 1'b0;
        end
      end
      ST_LOCK_B: begin
        b_grant_s = bus.b_valid;
      end
      default: begin
        a_grant_s = 1'b0;
        b_grant_s = 1'b0;
      end
    endcase

    a_ready_s = a_grant_s & rst_n;
    b_ready_s = b_grant_s & rst_n;
    a_xfer_s  = bus.a_valid & a_ready_s;
    b_xfer_s  = bus.b_valid & b_ready_s;

    if (a_xfer_s) begin
      last_b_nxt_s = 1'b0;
    end else if (b_xfer_s) begin
      last_b_nxt_s = 1'b1;
    end else begin
      last_b_nxt_s = last_b_r;
    end

    case (state_r)
      ST_ARB: begin
        if (b_xfer_s && bus.b_lock) begin
          state_nxt_s = ST_LOCK_B;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_LOCK_B: begin
        // Leaving a burst always hands the next tie to A.
        if (!bus.b_lock) begin
          state_nxt_s  = ST_ARB;
          last_b_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_LOCK_B;
        end
      end
      default: begin
        state_nxt_s = ST_ARB;
      end
    endcase
  end

  // FSM state and last-grant pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_ARB;
      last_b_r <= 1'b1;
    end else begin
      state_r  <= state_nxt_s;
      last_b_r <= last_b_nxt_s;
    end
  end

  // Write-port output register; x0 transfers are accepted but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= 5'd0;
      wr_data_r <= 32'd0;
      locked_r  <= 1'b0;
    end else begin
      if (a_xfer_s) begin
        wr_en_r   <= (bus.a_addr != 5'd0);
        wr_addr_r <= bus.a_addr;
        wr_data_r <= bus.a_data;
      end else if (b_xfer_s) begin
        wr_en_r   <= (bus.b_addr != 5'd0);
        wr_addr_r <= bus.b_addr;
        wr_data_r <= bus.b_data;
      end else begin
        wr_en_r   <= 1'b0;
        wr_addr_r <= wr_addr_r;
        wr_data_r <= wr_data_r;
      end
      locked_r <= (state_nxt_s == ST_LOCK_B);
    end
  end

  assign bus.a_ready  = a_ready_s;
  assign bus.b_ready  = b_ready_s;
  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr3 = wr_addr_r;
  assign bus.wr_data3 = wr_data_r;
  assign bus.locked   = locked_r;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: expected writes are queued at the grant and
// popped after the next clock edge.
module tb_rf_wr_arbiter;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  wr_t  sb_q[$];
  logic [4:0]  hold_addr;
  logic [31:0] hold_data;

  rf_wr_arbiter_if ifc ();

  rf_wr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: check readies mid-cycle, queue the expected write, check after the edge.
  task automatic step(input logic exp_a, input logic exp_b, input logic exp_lk, input string tag);
    wr_t exp_w;
    wr_t got_w;
    @(negedge clk);
    n_cmp++;
    if (ifc.a_ready !== exp_a) begin
      n_err++;
      $display("FAIL %s a_ready got %b want %b", tag, ifc.a_ready, exp_a);
    end
    n_cmp++;
    if (ifc.b_ready !== exp_b) begin
      n_err++;
      $display("FAIL %s b_ready got %b want %b", tag, ifc.b_ready, exp_b);
    end
    if (exp_a && ifc.a_valid) begin
      hold_addr = ifc.a_addr;
      hold_data = ifc.a_data;
      exp_w = '{en: (ifc.a_addr != 5'd0), addr: hold_addr, data: hold_data};
    end else if (exp_b && ifc.b_valid) begin
      hold_addr = ifc.b_addr;
      hold_data = ifc.b_data;
      exp_w = '{en: (ifc.b_addr != 5'd0), addr: hold_addr, data: hold_data};
    end else begin
      exp_w = '{en: 1'b0, addr: hold_addr, data: hold_data};
    end
    sb_q.push_back(exp_w);
    @(posedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard empty got 0 entries want 1", tag);
    end else begin
      exp_w = sb_q.pop_front();
      got_w = '{en: ifc.wr_en, addr: ifc.wr_addr3, data: ifc.wr_data3};
      if (got_w !== exp_w) begin
        n_err++;
        $display("FAIL %s write got en=%b a=%0d d=%h want en=%b a=%0d d=%h", tag,
                 got_w.en, got_w.addr, got_w.data, exp_w.en, exp_w.addr, exp_w.data);
      end
    end
    n_cmp++;
    if (ifc.locked !== exp_lk) begin
      n_err++;
      $display("FAIL %s locked got %b want %b", tag, ifc.locked, exp_lk);
    end
  endtask

  task automatic check_cleared(input string tag);
    n_cmp++;
    if ({ifc.a_ready, ifc.b_ready, ifc.wr_en, ifc.locked} !== 4'b0000) begin
      n_err++;
      $display("FAIL %s ctl got ar=%b br=%b en=%b lk=%b want 0000", tag,
               ifc.a_ready, ifc.b_ready, ifc.wr_en, ifc.locked);
    end
    n_cmp++;
    if ({ifc.wr_addr3, ifc.wr_data3} !== 37'd0) begin
      n_err++;
      $display("FAIL %s data got a=%0d d=%h want 0/0", tag, ifc.wr_addr3, ifc.wr_data3);
    end
  endtask

  task automatic idle_inputs();
    ifc.a_valid = 1'b0;
    ifc.b_valid = 1'b0;
    ifc.b_lock  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.a_valid = 1'b1; ifc.a_addr = 5'd3; ifc.a_data = 32'h1111_1111;
    ifc.b_valid = 1'b1; ifc.b_addr = 5'd4; ifc.b_data = 32'h2222_2222;
    ifc.b_lock  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    idle_inputs();
    rst_n = 1'b1;
    hold_addr = 5'd0;
    hold_data = 32'd0;
    sb_q.delete();
  endtask

  task automatic test_single_a();
    ifc.a_valid = 1'b1; ifc.a_addr = 5'd5; ifc.a_data = 32'hDEAD_BEEF;
    step(1'b1, 1'b0, 1'b0, "single_a");
    idle_inputs();
    step(1'b0, 1'b0, 1'b0, "single_a_idle");
  endtask

  task automatic test_x0();
    ifc.a_valid = 1'b1; ifc.a_addr = 5'd0; ifc.a_data = 32'h0000_1234;
    step(1'b1, 1'b0, 1'b0, "x0_write");
    idle_inputs();
    step(1'b0, 1'b0, 1'b0, "x0_idle");
  endtask

  task automatic test_contention();
    // A B-only write first so A owns the first tie.
    ifc.b_valid = 1'b1; ifc.b_addr = 5'd2; ifc.b_data = 32'hB000_0000;
    step(1'b0, 1'b1, 1'b0, "b_only");
    ifc.a_valid = 1'b1; ifc.a_addr = 5'd1;
    for (int i = 0; i < 4; i++) begin
      ifc.a_data = 32'hA000_0000 + 32'(i);
      ifc.b_data = 32'hB000_0100 + 32'(i);
`ifdef RF_WR_ARB_FIXED_PRIO_EN
      step(1'b1, 1'b0, 1'b0, "fixed_prio");
`else
      step(((i % 2) == 0), ((i % 2) == 1), 1'b0, "round_robin");
`endif
    end
    idle_inputs();
    step(1'b0, 1'b0, 1'b0, "contention_idle");
  endtask

  task automatic test_lock_burst();
    ifc.a_valid = 1'b1; ifc.a_addr = 5'd7; ifc.a_data = 32'h0000_0A0A;
    step(1'b1, 1'b0, 1'b0, "pre_lock_a");
`ifdef RF_WR_ARB_FIXED_PRIO_EN
    ifc.a_valid = 1'b0;
`endif
    ifc.b_valid = 1'b1; ifc.b_lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifc.b_addr = 5'd10 + 5'(i);
      ifc.b_data = 32'hC0DE_0000 + 32'(i);
      step(1'b0, 1'b1, 1'b1, "lock_burst");
      ifc.a_valid = 1'b1;
    end
    ifc.b_lock = 1'b0; ifc.b_addr = 5'd14; ifc.b_data = 32'hC0DE_00FF;
    step(1'b0, 1'b1, 1'b0, "lock_exit");
    step(1'b1, 1'b0, 1'b0, "after_lock_tie");
    ifc.a_valid = 1'b0;
    step(1'b0, 1'b1, 1'b0, "after_lock_b");
    idle_inputs();
    step(1'b0, 1'b0, 1'b0, "lock_idle");
  endtask

  task automatic test_reset_mid_burst();
    ifc.b_valid = 1'b1; ifc.b_lock = 1'b1; ifc.b_addr = 5'd20; ifc.b_data = 32'h5555_0000;
    step(1'b0, 1'b1, 1'b1, "burst_start");
    ifc.b_addr = 5'd21; ifc.b_data = 32'h5555_0001;
    step(1'b0, 1'b1, 1'b1, "burst_cont");
    rst_n = 1'b0;
    #1;
    check_cleared("reset_mid_burst");
    hold_addr = 5'd0;
    hold_data = 32'd0;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ifc.b_lock = 1'b0;
    ifc.a_valid = 1'b1; ifc.a_addr = 5'd9; ifc.a_data = 32'h9999_9999;
    ifc.b_addr = 5'd22;
    step(1'b1, 1'b0, 1'b0, "post_reset_tie");
    idle_inputs();
    step(1'b0, 1'b0, 1'b0, "post_reset_idle");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    hold_addr = 5'd0;
    hold_data = 32'd0;
    test_reset();
    test_single_a();
    test_x0();
    test_contention();
    test_lock_burst();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
